// File: rtl/ann_mux_sequencer_if.sv
// ann_mux_sequencer_if: start, mux select/data and the valid/ready stream to the activation stage
interface ann_mux_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
);
  logic              iStart;
  logic [SEL_W-1:0]  oSel;
  logic [DATA_W-1:0] iMux_data;
  logic [DATA_W-1:0] oData;
  logic [SEL_W-1:0]  oIdx;
  logic              oValid;
  logic              oLast;
  logic              iReady;
  logic              oBusy;
  logic              oDone;
  modport master (
    input  iStart, iMux_data, iReady,
    output oSel, oData, oIdx, oValid, oLast, oBusy, oDone
  );
  modport slave (
    output iStart, iMux_data, iReady,
    input  oSel, oData, oIdx, oValid, oLast, oBusy, oDone
  );
endinterface

// File: rtl/ann_mux_sequencer.sv
// ann_mux_sequencer: walks the MAC-result mux select and streams each sum downstream, then pulses done
module ann_mux_sequencer #(
  parameter int NUM_NEURON = 20,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 5
) (
  input logic                  iClk,
  input logic                  iRst_n,
  ann_mux_sequencer_if.master  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_NEURON - 1);
  state_t state;
  logic load;
  logic atLast;
  assign load   = !bus.oValid || bus.iReady;
  assign atLast = bus.oSel == LAST_SEL;
  // Sequencer FSM; every output is a register updated alongside the state
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state      <= IDLE;
      bus.oSel   <= '0;
      bus.oData  <= {DATA_W{1'b0}};
      bus.oIdx   <= '0;
      bus.oValid <= 1'b0;
      bus.oLast  <= 1'b0;
      bus.oBusy  <= 1'b0;
      bus.oDone  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.iStart) begin
          state    <= RUN;
          bus.oBusy <= 1'b1;
          bus.oSel  <= '0;
        end
        RUN: if (load) begin
          bus.oData  <= bus.iMux_data;
          bus.oIdx   <= bus.oSel;
          bus.oValid <= 1'b1;
          bus.oLast  <= atLast;
          if (atLast) state <= DRAIN;
          else bus.oSel <= bus.oSel + SEL_W'(1);
        end
        DRAIN: if (bus.iReady) begin
          state      <= DONE;
          bus.oValid <= 1'b0;
          bus.oLast  <= 1'b0;
          bus.oDone  <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          bus.oDone <= 1'b0;
          bus.oBusy <= 1'b0;
          bus.oSel  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ann_mux_sequencer.sv
// tb_ann_mux_sequencer: vector table plus randomized scoreboard checks of the mux sequencer
module tb_ann_mux_sequencer;
  localparam int N = 20;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [31:0] muxBase = 32'h1000_0000;
  int passCnt = 0;
  int totalCnt = 0;
  ann_mux_sequencer_if #(.DATA_W(32), .SEL_W(5)) bus ();
  ann_mux_sequencer #(.NUM_NEURON(N), .DATA_W(32), .SEL_W(5)) dut (
    .iClk(clk),
    .iRst_n(rstN),
    .bus(bus)
  );
  assign bus.iMux_data = muxBase + 32'(bus.oSel);
  always #5 clk = ~clk;
  typedef struct {
    logic start, ready, expValid, expLast, expBusy, expDone;
    logic [4:0] expIdx, expSel;
  } vec_t;
  vec_t vecs[25];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic checkIdle(input string tag);
    check({tag, " sel"}, 32'(bus.oSel), 0);
    check({tag, " data"}, bus.oData, 0);
    check({tag, " idx"}, 32'(bus.oIdx), 0);
    check({tag, " valid"}, 32'(bus.oValid), 0);
    check({tag, " last"}, 32'(bus.oLast), 0);
    check({tag, " busy"}, 32'(bus.oBusy), 0);
    check({tag, " done"}, 32'(bus.oDone), 0);
  endtask
  // mode 0: ready always 1; 1: random ready; 2: stall 5 cycles on last word; 3: extra starts while busy
  task automatic runStream(input int mode, input string tag);
    int expNext = 0;
    int cyc = 0;
    int stallLeft = 5;
    int doneCyc = -1;
    logic pend = 1'b0;
    logic pStall = 1'b0;
    logic [31:0] pData = 0;
    logic [4:0] pIdx = 0;
    logic pLast = 1'b0;
    logic xfer;
    bus.iStart = 1'b1;
    bus.iReady = 1'b1;
    step();
    cyc = 1;
    while (doneCyc < 0 && cyc < 400) begin
      bus.iStart = 1'b0;
      if (pStall) begin
        check({tag, " hold valid"}, 32'(bus.oValid), 1);
        check({tag, " hold data"}, bus.oData, pData);
        check({tag, " hold idx"}, 32'(bus.oIdx), 32'(pIdx));
        check({tag, " hold last"}, 32'(bus.oLast), 32'(pLast));
      end
      check({tag, " done"}, 32'(bus.oDone), 32'(pend));
      check({tag, " busy"}, 32'(bus.oBusy), 1);
      if (bus.oDone) doneCyc = cyc;
      if (mode == 3) bus.iStart = (cyc == 5) || bus.oDone;
      if (mode == 1) bus.iReady = 1'($urandom_range(0, 1));
      else if (mode == 2 && bus.oValid && bus.oIdx == 5'(N - 1) && stallLeft > 0) begin
        bus.iReady = 1'b0;
        stallLeft--;
        check({tag, " stall sel"}, 32'(bus.oSel), N - 1);
        check({tag, " stall last"}, 32'(bus.oLast), 1);
        check({tag, " stall data"}, bus.oData, muxBase + 32'(N - 1));
      end else bus.iReady = 1'b1;
      xfer = bus.oValid && bus.iReady;
      pend = 1'b0;
      if (xfer) begin
        check({tag, " idx"}, 32'(bus.oIdx), expNext);
        check({tag, " data"}, bus.oData, muxBase + 32'(expNext));
        check({tag, " last"}, 32'(bus.oLast), 32'(expNext == N - 1));
        pend = (expNext == N - 1);
        expNext++;
      end
      pStall = bus.oValid && !bus.iReady;
      pData = bus.oData;
      pIdx = bus.oIdx;
      pLast = bus.oLast;
      step();
      cyc++;
    end
    bus.iStart = 1'b0;
    bus.iReady = 1'b1;
    check({tag, " done seen"}, 32'(doneCyc >= 0), 1);
    check({tag, " xfer count"}, expNext, N);
    if (mode == 0 || mode == 3) check({tag, " done cycle"}, doneCyc, N + 2);
    check({tag, " idle busy"}, 32'(bus.oBusy), 0);
    check({tag, " idle sel"}, 32'(bus.oSel), 0);
    check({tag, " idle valid"}, 32'(bus.oValid), 0);
    check({tag, " idle done"}, 32'(bus.oDone), 0);
    step();
    check({tag, " stays idle"}, 32'(bus.oBusy), 0);
  endtask
  initial begin
    int c;
    for (int i = 0; i < 25; i++) begin
      vecs[i].start = (i == 0);
      vecs[i].ready = 1'b1;
      vecs[i].expValid = (i >= 2 && i <= N + 1);
      vecs[i].expIdx = 5'((i >= 2 && i <= N + 1) ? i - 2 : 0);
      vecs[i].expLast = (i == N + 1);
      vecs[i].expBusy = (i >= 1 && i <= N + 2);
      vecs[i].expDone = (i == N + 2);
      vecs[i].expSel = 5'((i <= 1 || i > N + 2) ? 0 : (i - 1 > N - 1 ? N - 1 : i - 1));
    end
    bus.iStart = 1'b0;
    bus.iReady = 1'b1;
    step();
    step();
    checkIdle("reset");
    rstN = 1'b1;
    for (int i = 0; i < 25; i++) begin
      bus.iStart = vecs[i].start;
      bus.iReady = vecs[i].ready;
      check($sformatf("vec%0d valid", i), 32'(bus.oValid), 32'(vecs[i].expValid));
      check($sformatf("vec%0d busy", i), 32'(bus.oBusy), 32'(vecs[i].expBusy));
      check($sformatf("vec%0d done", i), 32'(bus.oDone), 32'(vecs[i].expDone));
      check($sformatf("vec%0d sel", i), 32'(bus.oSel), 32'(vecs[i].expSel));
      if (vecs[i].expValid) begin
        check($sformatf("vec%0d idx", i), 32'(bus.oIdx), 32'(vecs[i].expIdx));
        check($sformatf("vec%0d last", i), 32'(bus.oLast), 32'(vecs[i].expLast));
        check($sformatf("vec%0d data", i), bus.oData, 32'h1000_0000 + 32'(vecs[i].expIdx));
      end
      step();
    end
    bus.iStart = 1'b0;
    runStream(0, "basic");
    for (int r = 0; r < 4; r++) begin
      muxBase = $urandom;
      runStream(1, $sformatf("bp%0d", r));
    end
    muxBase = 32'h1000_0000;
    runStream(2, "stall_last");
    runStream(3, "start_busy");
    bus.iReady = 1'b1;
    bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
    c = 0;
    while (!(bus.oValid && bus.oIdx == 5'd7) && c < 100) begin
      step();
      c++;
    end
    check("rst reach idx7", 32'(c < 100), 1);
    step();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    checkIdle("rst mid");
    c = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.oDone || bus.oBusy || bus.oValid) c++;
      step();
    end
    check("rst no activity", c, 0);
    runStream(0, "after_rst");
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/ann_mux_sequencer.md
Name: ann_mux_sequencer

Overview:
- Sequences the 20-to-1 MAC-result multiplexer of the ANN hidden/output layer.
- Once all MAC accumulators hold final sums, it walks the mux select from 0 to NUM_NEURON-1.
- It registers each selected 32-bit sum and streams the sums one per cycle to the downstream activation (sigmoid LUT) stage over a valid/ready handshake, then pulses done.

Parameters:
- NUM_NEURON, 20, number of mux inputs to stream (1..2^SEL_W).
- DATA_W, 32, width of MAC sums and output data.
- SEL_W, 5, width of mux select and index outputs.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  synchronous active-low reset.
- iStart  input  1  single-cycle pulse: MAC sums are final, begin streaming.
- oSel  output  SEL_W  select driven to the mux iSel.
- iMux_data  input  DATA_W  mux output; combinational function of oSel.
- oData  output  DATA_W  registered neuron sum to the activation stage.
- oIdx  output  SEL_W  neuron index of oData.
- oValid  output  1  oData/oIdx valid.
- oLast  output  1  qualifies oData as index NUM_NEURON-1.
- iReady  input  1  downstream accepts when oValid and iReady are both high.
- oBusy  output  1  high in every state except IDLE.
- oDone  output  1  single-cycle pulse after the final transfer.

Behaviour:
- Reset: iRst_n low at a rising edge puts every register in its reset state, in any state and mid-stream.
  - State=IDLE.
  - oSel=0, oData=0, oIdx=0.
  - oValid=0, oLast=0, oBusy=0, oDone=0.
  - A partial stream is abandoned; no oDone is issued for it.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - oSel=0.
  - iStart=1 -> RUN, with oSel=0.
- RUN:
  - load = (!oValid || iReady).
  - On load, at the edge: oData<=iMux_data, oIdx<=oSel, oValid<=1, oLast<=(oSel==NUM_NEURON-1).
  - If the loaded oSel==NUM_NEURON-1 -> DRAIN, oSel held. Otherwise oSel<=oSel+1.
  - Without load, oSel, oData, oIdx and oLast hold; oSel never wraps.
- DRAIN:
  - Holds the final word.
  - On oValid&&iReady -> DONE, with oValid<=0 and oLast<=0.
- DONE:
  - oDone=1 for exactly one cycle, then -> IDLE with oSel<=0.
  - oBusy is still 1 during DONE.
- Handshake rules:
  - oData, oIdx and oLast are stable while oValid=1 and iReady=0.
  - oValid never drops without a transfer, except on reset.
  - Zero-bubble streaming: throughput is 1 word/cycle while iReady=1.
- Latency, with iStart sampled at cycle 0:
  - RUN during cycle 1 with oSel=0.
  - Word 0 valid in cycle 2.
  - With iReady held 1, words 0..NUM_NEURON-1 transfer in cycles 2..NUM_NEURON+1.
  - oDone=1 in cycle NUM_NEURON+2; IDLE in cycle NUM_NEURON+3.
- iStart outside IDLE is ignored and not queued.
- iMux_data is sampled only on a load edge; its value at other times is don't-care.
- oIdx equals the mux index of oData; the stream order is strictly 0,1,…,NUM_NEURON-1, each exactly once.
- NUM_NEURON=1: the single word carries oLast=1, then DRAIN, then DONE.

Test Plan:
- Basic stream:
  - Stimulus: mux model returns 32'h1000_0000+sel; iReady=1; iStart at cycle 0.
  - Response: oValid cycles 2..21, oData=0x1000_0000..0x1000_0013, oIdx=0..19, oLast only at idx 19; oDone at cycle 22; oBusy cycles 1..22.
- Backpressure:
  - Stimulus: iReady toggled 1,0,0,1,… pseudo-randomly.
  - Response: oData/oIdx held while stalled; exactly 20 transfers, in order, with no duplicates or drops; oDone 1 cycle after the 20th transfer.
- Stall on last word:
  - Stimulus: iReady=0 for 5 cycles once idx 19 is presented.
  - Response: state DRAIN; oData=0x1000_0013 and oLast=1 held; oDone only after the accept.
- Start while busy:
  - Stimulus: second iStart pulses at cycles 5 and 22.
  - Response: both ignored; a single 20-word stream; oSel=0 after IDLE.
- Reset mid-stream:
  - Stimulus: iRst_n=0 for one edge after idx 7 is transferred.
  - Response: next cycle all outputs at reset values and no oDone; a fresh iStart yields a full stream starting at idx 0.
